// File: rtl/scanline_irq_unit_pkg.sv
// Shared constants for the scanline IRQ unit: register map, CTRL/STATUS bit
// positions, counting mode and legal parameter ranges.
package scanline_irq_unit_pkg;

  localparam int PPU_ADDR_W = 14;

  localparam logic [3:0] REG_CTRL    = 4'h0;
  localparam logic [3:0] REG_STATUS  = 4'h1;
  localparam logic [3:0] REG_COUNT   = 4'h2;
  localparam int         REG_CH_BASE = 4;

  localparam int CTRL_GE_BIT      = 7;
  localparam int CTRL_MODE_BIT    = 0;
  localparam int CH_EN_BIT        = 7;
  localparam int STATUS_IRQ_BIT   = 7;
  localparam int STATUS_FRAME_BIT = 6;

  localparam int CNT_W_MIN   = 4;
  localparam int CNT_W_MAX   = 8;
  localparam int NCH_MIN     = 1;
  localparam int NCH_MAX     = 6;
  localparam int SAME_RD_MIN = 2;
  localparam int SAME_RD_MAX = 4;

  typedef enum logic {
    MODE_SCANLINE = 1'b0,
    MODE_M2       = 1'b1
  } mode_e;

  // Each channel owns a compare/enable register pair starting at REG_CH_BASE.
  function automatic logic [3:0] ch_cmp_addr(input int n);
    return 4'(REG_CH_BASE + 2 * n);
  endfunction

  function automatic logic [3:0] ch_en_addr(input int n);
    return 4'(REG_CH_BASE + 2 * n + 1);
  endfunction

endpackage

// File: rtl/scanline_irq_unit_if.sv
// Host-facing bundle of the scanline IRQ unit: PPU/CPU snoop inputs, register
// bus and interrupt outputs.
interface scanline_irq_unit_if;
  import scanline_irq_unit_pkg::*;

  logic                  m2_fall;
  logic                  ppu_rd;
  logic [PPU_ADDR_W-1:0] ppu_addr;
  logic                  bgr_on;
  logic                  reg_we;
  logic                  reg_re;
  logic [3:0]            reg_addr;
  logic [7:0]            reg_di;
  logic [7:0]            reg_do;
  logic                  irq;
  logic                  in_frame;

  modport master (
    output m2_fall, ppu_rd, ppu_addr, bgr_on, reg_we, reg_re, reg_addr, reg_di,
    input  reg_do, irq, in_frame
  );

  modport slave (
    input  m2_fall, ppu_rd, ppu_addr, bgr_on, reg_we, reg_re, reg_addr, reg_di,
    output reg_do, irq, in_frame
  );

endinterface

// File: rtl/scanline_irq_unit_ppu_line_detect.sv
// Watches PPU reads: pulses once when SAME_RD consecutive reads hit the same
// address (end of a scanline) and flags IDLE_CYC cycles without any read.
module ppu_line_detect
  import scanline_irq_unit_pkg::*;
#(
  parameter int SAME_RD  = 3,
  parameter int IDLE_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ppu_rd,
  input  logic [PPU_ADDR_W-1:0] i_ppu_addr,
  output logic                  o_line,
  output logic                  o_idle
);

  localparam int IW = $clog2(IDLE_CYC + 1);

  logic [PPU_ADDR_W-1:0] r_last_addr;
  logic [2:0]            r_run;
  logic [IW-1:0]         r_idle_cnt;
  logic                  w_same;

  // r_run = length of the current identical-address run, saturating at SAME_RD
  // so the pulse fires once per run.
  assign w_same = (r_run != 3'd0) && (i_ppu_addr == r_last_addr);
  assign o_line = i_ppu_rd && w_same && (r_run == 3'(SAME_RD - 1));
  assign o_idle = !i_ppu_rd && (r_idle_cnt == IW'(IDLE_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_addr <= '0;
      r_run       <= 3'd0;
      r_idle_cnt  <= '0;
    end else if (i_ppu_rd) begin
      r_last_addr <= i_ppu_addr;
      r_idle_cnt  <= '0;
      if (!w_same)                      r_run <= 3'd1;
      else if (r_run != 3'(SAME_RD))    r_run <= r_run + 3'd1;
    end else if (r_idle_cnt != IW'(IDLE_CYC - 1)) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scanline_irq_unit.sv
// Scanline / M2-cycle interrupt unit: frame tracking, saturating counter,
// NCH compare channels with pending bits, and a registered IRQ.
module scanline_irq_unit
  import scanline_irq_unit_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int NCH      = 2,
  parameter int IDLE_CYC = 64,
  parameter int SAME_RD  = 3
) (
  input  logic               clk,
  input  logic               rst,
  scanline_irq_unit_if.slave bus
);

  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX || NCH < NCH_MIN || NCH > NCH_MAX ||
      SAME_RD < SAME_RD_MIN || SAME_RD > SAME_RD_MAX || IDLE_CYC < 1) begin : g_param_check
    $error("scanline_irq_unit: parameter out of legal range");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_ge;
  mode_e            r_mode;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_cmp [NCH];
  logic [NCH-1:0]   r_en;
  logic [NCH-1:0]   r_pending;
  logic             r_in_frame;
  logic             r_irq;

  logic             w_line, w_idle;
  logic             w_wr_ctrl, w_wr_status, w_rd_status, w_mode_chg;
  logic             w_frame_start, w_any_irq;
  logic [NCH-1:0]   w_cmp_we, w_en_we, w_match, w_pend_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [7:0]       w_rd_data;

  ppu_line_detect #(.SAME_RD(SAME_RD), .IDLE_CYC(IDLE_CYC)) u_detect (
    .clk        (clk),
    .rst        (rst),
    .i_ppu_rd   (bus.ppu_rd),
    .i_ppu_addr (bus.ppu_addr),
    .o_line     (w_line),
    .o_idle     (w_idle)
  );

  assign w_wr_ctrl     = bus.reg_we && (bus.reg_addr == REG_CTRL);
  assign w_wr_status   = bus.reg_we && (bus.reg_addr == REG_STATUS);
  assign w_rd_status   = bus.reg_re && (bus.reg_addr == REG_STATUS);
  assign w_mode_chg    = w_wr_ctrl && (mode_e'(bus.reg_di[CTRL_MODE_BIT]) != r_mode);
  assign w_frame_start = w_line && bus.bgr_on && !r_in_frame;
  assign w_any_irq     = r_ge && |(r_pending & r_en);

  always_comb begin
    // NOTE: defaults first, so no path through this block leaves an output unassigned and infers a latch.
    w_cmp_we = '0;
    w_en_we  = '0;
    for (int n = 0; n < NCH; n++) begin
      w_cmp_we[n] = bus.reg_we && (bus.reg_addr == ch_cmp_addr(n));
      w_en_we[n]  = bus.reg_we && (bus.reg_addr == ch_en_addr(n));
    end
  end

  // A mode switch restarts counting; a frame start wins over any match since it forces count to 0.
  always_comb begin
    w_count_nxt = r_count;
    if (w_mode_chg) begin
      w_count_nxt = '0;
    end else if (r_mode == MODE_SCANLINE) begin
      if (w_frame_start)                                     w_count_nxt = '0;
      else if (r_in_frame && w_line && r_count != CNT_MAX)   w_count_nxt = r_count + 1'b1;
    end else if (bus.m2_fall && r_count != CNT_MAX) begin
      w_count_nxt = r_count + 1'b1;
    end

    w_match = '0;
    for (int n = 0; n < NCH; n++)
      w_match[n] = (w_count_nxt != r_count) && (w_count_nxt == r_cmp[n]) && (r_cmp[n] != '0);

    w_pend_nxt = r_pending;
    if (w_frame_start && r_mode == MODE_SCANLINE) w_pend_nxt = '0;
    if (w_rd_status)                              w_pend_nxt = '0;
    if (w_wr_status)                              w_pend_nxt = w_pend_nxt & ~bus.reg_di[NCH-1:0];
    w_pend_nxt = w_pend_nxt | w_match;
  end

  always_comb begin
    w_rd_data = '0;
    case (bus.reg_addr)
      REG_CTRL: begin
        w_rd_data[CTRL_GE_BIT]   = r_ge;
        w_rd_data[CTRL_MODE_BIT] = r_mode;
      end
      REG_STATUS: begin
        w_rd_data[STATUS_IRQ_BIT]   = w_any_irq;
        w_rd_data[STATUS_FRAME_BIT] = r_in_frame;
        w_rd_data[NCH-1:0]          = r_pending;
      end
      REG_COUNT: w_rd_data[CNT_W-1:0] = r_count;
      default: begin
        for (int n = 0; n < NCH; n++) begin
          if (bus.reg_addr == ch_cmp_addr(n)) w_rd_data[CNT_W-1:0] = r_cmp[n];
          if (bus.reg_addr == ch_en_addr(n))  w_rd_data[CH_EN_BIT] = r_en[n];
        end
      end
    endcase
  end

  assign bus.reg_do   = bus.reg_re ? w_rd_data : 8'h00;
  assign bus.irq      = r_irq;
  assign bus.in_frame = r_in_frame;

  // NOTE: the compare array is plain flops, not RAM, so it is reset with everything else and starts at "never match".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ge       <= 1'b0;
      r_mode     <= MODE_SCANLINE;
      r_count    <= '0;
      r_en       <= '0;
      r_pending  <= '0;
      r_in_frame <= 1'b0;
      r_irq      <= 1'b0;
      for (int n = 0; n < NCH; n++) r_cmp[n] <= '0;
    end else begin
      // NOTE: non-blocking here so every register samples pre-edge values, regardless of statement order.
      if (w_wr_ctrl) begin
        r_ge   <= bus.reg_di[CTRL_GE_BIT];
        r_mode <= mode_e'(bus.reg_di[CTRL_MODE_BIT]);
      end
      for (int n = 0; n < NCH; n++) begin
        if (w_cmp_we[n]) r_cmp[n] <= bus.reg_di[CNT_W-1:0];
        if (w_en_we[n])  r_en[n]  <= bus.reg_di[CH_EN_BIT];
      end
      r_count   <= w_count_nxt;
      r_pending <= w_pend_nxt;
      r_irq     <= w_any_irq;
      if (w_frame_start)              r_in_frame <= 1'b1;
      else if (!bus.bgr_on || w_idle) r_in_frame <= 1'b0;
    end
  end

endmodule
